// File: rtl/mem_arb_ctrl.sv
// rtl/mem_arb_ctrl.sv - multi-port byte-serial memory arbiter and transfer controller (optional MEM_ARB_RR_EN: round-robin grant)
module mem_arb_ctrl #(
    parameter int NPORT  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy_in,
    input  logic [NPORT-1:0]        req_valid,
    input  logic [NPORT-1:0]        req_wr,
    input  logic [NPORT*ADDR_W-1:0] req_addr,
    input  logic [NPORT*32-1:0]     req_wdata,
    input  logic [NPORT*2-1:0]      req_len,
    output logic [NPORT-1:0]        resp_done,
    output logic [31:0]             resp_rdata,
    output logic                    busy,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_W-1:0]       mem_a,
    output logic                    mem_wr
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          len_q, len_d;
    logic [1:0]          port_q, port_d;
    // index of the byte whose address is on mem_a (0..len, len+1 once all issued)
    logic [2:0]          a_idx_q, a_idx_d;
    // a read was issued last active cycle; mem_din now carries byte pend_idx
    logic                pend_q, pend_d;
    logic [1:0]          pend_idx_q, pend_idx_d;
    // an in-flight read was lost to a stall; re-address byte pend_idx on resume
    logic                redo_q, redo_d;
    logic [31:0]         buf_q, buf_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;
    logic                busy_q, busy_d;
    logic [NPORT-1:0]    done_q, done_d;

    logic                gnt_any;
    logic [1:0]          gnt_idx;
    logic [2:0]          nxt_idx;

`ifdef MEM_ARB_RR_EN
    // index where the next search starts (one past the last granted port)
    logic [1:0]          ptr_q;

    // round-robin winner search starting at ptr_q
    always_comb begin : arb_rr
        int p;
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        p       = 0;
        for (int k = 0; k < NPORT; k++) begin
            p = (int'(ptr_q) + k) % NPORT;
            if (!gnt_any && req_valid[p]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(p);
            end
        end
    end

    // advance the search start past the port that just won
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else if (state_q == S_IDLE && rdy_in && gnt_any) begin
            ptr_q <= (int'(gnt_idx) == NPORT - 1) ? 2'd0 : gnt_idx + 2'd1;
        end
    end
`else
    // fixed priority: lowest-index valid port wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(k);
            end
        end
    end
`endif

    // next-state and registered-output computation for the transfer FSM
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        port_d     = port_q;
        a_idx_d    = a_idx_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        redo_d     = redo_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        nxt_idx    = a_idx_q + 3'd1;

        case (state_q)
            S_IDLE: begin
                if (rdy_in && gnt_any) begin
                    wr_d       = req_wr[gnt_idx];
                    addr_d     = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                    wdata_d    = req_wdata[int'(gnt_idx)*32 +: 32];
                    len_d      = req_len[int'(gnt_idx)*2 +: 2];
                    port_d     = gnt_idx;
                    a_idx_d    = 3'd0;
                    pend_d     = 1'b0;
                    redo_d     = 1'b0;
                    buf_d      = 32'd0;
                    busy_d     = 1'b1;
                    mem_a_d    = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                    if (req_wr[gnt_idx]) begin
                        state_d    = S_WRITE;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = req_wdata[int'(gnt_idx)*32 +: 8];
                    end else begin
                        state_d    = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (rdy_in) begin
                    if (a_idx_q[1:0] == len_q) begin
                        state_d  = S_DONE;
                        mem_wr_d = 1'b0;
                        done_d   = NPORT'(1) << port_q;
                    end else begin
                        a_idx_d    = nxt_idx;
                        mem_a_d    = mem_a_q + ADDR_W'(1);
                        mem_dout_d = wdata_q[{nxt_idx[1:0], 3'b000} +: 8];
                    end
                end
            end
            S_READ: begin
                if (!rdy_in) begin
                    if (pend_q) begin
                        pend_d = 1'b0;
                        redo_d = 1'b1;
                    end
                end else if (redo_q) begin
                    redo_d  = 1'b0;
                    a_idx_d = {1'b0, pend_idx_q};
                    mem_a_d = addr_q + ADDR_W'(pend_idx_q);
                end else begin
                    if (pend_q) begin
                        buf_d[{pend_idx_q, 3'b000} +: 8] = mem_din;
                    end
                    if (pend_q && pend_idx_q == len_q) begin
                        state_d = S_DONE;
                        pend_d  = 1'b0;
                        rdata_d = buf_d;
                        done_d  = NPORT'(1) << port_q;
                    end else if (a_idx_q <= {1'b0, len_q}) begin
                        pend_d     = 1'b1;
                        pend_idx_d = a_idx_q[1:0];
                        a_idx_d    = nxt_idx;
                        if (a_idx_q[1:0] != len_q) begin
                            mem_a_d = mem_a_q + ADDR_W'(1);
                        end
                    end else begin
                        pend_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (rdy_in) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state register with synchronous reset that aborts any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            len_q      <= 2'd0;
            port_q     <= 2'd0;
            a_idx_q    <= 3'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            redo_q     <= 1'b0;
            buf_q      <= 32'd0;
            rdata_q    <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            port_q     <= port_d;
            a_idx_q    <= a_idx_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            redo_q     <= redo_d;
            buf_q      <= buf_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // a frozen cycle never writes memory and never signals completion
    assign mem_wr     = mem_wr_q & rdy_in;
    assign resp_done  = done_q & {NPORT{rdy_in}};
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign resp_rdata = rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb/tb_mem_arb_ctrl.sv - directed self-checking bench for mem_arb_ctrl
module tb_mem_arb_ctrl;

    logic        clk, rst, rdy_in;
    logic [1:0]  req_valid, req_wr;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_len;
    logic [1:0]  resp_done;
    logic [31:0] resp_rdata;
    logic        busy;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  mem_arr [16];
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    logic [31:0] alog[$];
    int          done_cnt[2];
    int          checks, errors;

    mem_arb_ctrl #(.NPORT(2), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_len(req_len),
        .resp_done(resp_done), .resp_rdata(resp_rdata), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle-latency read memory
    always @(posedge clk) mem_din <= mem_arr[mem_a[3:0]];

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr) begin
                wlog_a.push_back(mem_a);
                wlog_d.push_back(mem_dout);
            end
            if (busy && resp_done == 2'b00 && rdy_in && !mem_wr) alog.push_back(mem_a);
            for (int i = 0; i < 2; i++) if (resp_done[i]) done_cnt[i]++;
        end
    end

    task automatic clear_logs;
        wlog_a.delete();
        wlog_d.delete();
        alog.delete();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    endtask

    task automatic drive_req(input int p, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] len);
        req_wr[p]           = wr;
        req_addr[p*32 +: 32]  = a;
        req_wdata[p*32 +: 32] = d;
        req_len[p*2 +: 2]     = len;
        req_valid[p]        = 1'b1;
    endtask

    task automatic wait_done(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (resp_done[p]) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy_in = 1'b1;
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_len = '0;
        for (int i = 0; i < 16; i++) mem_arr[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
        checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
        checks++; if (resp_done !== 2'b00) begin errors++; $display("FAIL reset_resp_done: got %b expected 00", resp_done); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write;
        bit ok;
        logic [7:0] ed [4];
        ed = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(posedge clk); #1;
        clear_logs();
        drive_req(0, 1'b1, 32'h100, 32'hDDCCBBAA, 2'd3);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_grant_busy: got %b expected 0", busy); end
        wait_done(0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_done_timeout: got %b expected 1", ok); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_in_done: got %b expected 1", busy); end
        @(posedge clk); #1 req_valid[0] = 1'b0;
        checks++; if (wlog_a.size() != 4) begin errors++; $display("FAIL write_count: got %0d expected 4", wlog_a.size()); end
        for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
            checks++;
            if (wlog_a[i] !== 32'h100 + 32'(i) || wlog_d[i] !== ed[i]) begin
                errors++;
                $display("FAIL write_byte%0d: got a=%h d=%h expected a=%h d=%h", i, wlog_a[i], wlog_d[i], 32'h100 + 32'(i), ed[i]);
            end
        end
        checks++; if (done_cnt[0] != 1 || done_cnt[1] != 0) begin errors++; $display("FAIL write_done_cnt: got %0d/%0d expected 1/0", done_cnt[0], done_cnt[1]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after: got %b expected 0", busy); end
    endtask

    task automatic do_read(input int p, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] exp_d, input int exp_cyc, input string nm);
        bit ok;
        @(posedge clk); #1;
        clear_logs();
        drive_req(p, 1'b0, a, 32'h0, len);
        wait_done(p, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s_timeout: got %b expected 1", nm, ok); end
        checks++; if (resp_rdata !== exp_d) begin errors++; $display("FAIL %s_rdata: got %h expected %h", nm, resp_rdata, exp_d); end
        @(posedge clk); #1 req_valid[p] = 1'b0;
        checks++; if (alog.size() != exp_cyc) begin errors++; $display("FAIL %s_read_cycles: got %0d expected %0d", nm, alog.size(), exp_cyc); end
        checks++; if (done_cnt[p] != 1 || done_cnt[1-p] != 0 || wlog_a.size() != 0) begin
            errors++; $display("FAIL %s_done_cnt: got %0d/%0d writes %0d expected 1/0 writes 0", nm, done_cnt[p], done_cnt[1-p], wlog_a.size());
        end
    endtask

    task automatic test_read;
        mem_arr[0] = 8'h34; mem_arr[1] = 8'h12;
        do_read(1, 32'h200, 2'd1, 32'h00001234, 3, "read2");
        mem_arr[5] = 8'hA7;
        do_read(0, 32'h205, 2'd0, 32'h000000A7, 2, "read1_zext");
    endtask

    task automatic test_arbitration;
        logic [1:0] got [4];
        logic [1:0] exp [4];
        int seen;
`ifdef MEM_ARB_RR_EN
        exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        seen = 0;
        @(posedge clk); #1;
        clear_logs();
        drive_req(0, 1'b1, 32'h400, 32'h11, 2'd0);
        drive_req(1, 1'b1, 32'h500, 32'h22, 2'd0);
        for (int i = 0; i < 200 && seen < 4; i++) begin
            @(negedge clk);
            if (resp_done != 2'b00) begin
                got[seen] = resp_done;
                seen++;
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        checks++; if (seen != 4) begin errors++; $display("FAIL arb_timeout: got %0d grants expected 4", seen); end
        for (int i = 0; i < seen; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL arb_grant%0d: got %b expected %b", i, got[i], exp[i]); end
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle_busy: got %b expected 0", busy); end
        checks++; if (resp_rdata !== 32'h000000A7) begin errors++; $display("FAIL rdata_stable: got %h expected 000000a7", resp_rdata); end
    endtask

    task automatic test_stall_read;
        bit ok;
        bit hit;
        for (int i = 8; i < 12; i++) mem_arr[i] = 8'(8'h11 * (i - 7));
        @(posedge clk); #1;
        clear_logs();
        drive_req(0, 1'b0, 32'h208, 32'h0, 2'd3);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (mem_a === 32'h20A) hit = 1'b1;
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL stall_reach_byte2: got %b expected 1", hit); end
        @(posedge clk); #1;
        rdy_in = 1'b0;
        mem_arr[10] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_wr !== 1'b0 || mem_a !== 32'h20B || busy !== 1'b1 || resp_done !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold%0d: got wr=%b a=%h busy=%b done=%b expected wr=0 a=0000020b busy=1 done=00", i, mem_wr, mem_a, busy, resp_done);
            end
        end
        @(posedge clk); #1 rdy_in = 1'b1;
        wait_done(0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout: got %b expected 1", ok); end
        checks++; if (resp_rdata !== 32'h443C2211) begin errors++; $display("FAIL stall_rdata: got %h expected 443c2211", resp_rdata); end
        @(posedge clk); #1 req_valid[0] = 1'b0;
    endtask

    task automatic test_wrap;
        logic [31:0] ea [4];
        ea = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        mem_arr[14] = 8'h01; mem_arr[15] = 8'h02; mem_arr[0] = 8'h03; mem_arr[1] = 8'h04;
        do_read(1, 32'hFFFFFFFE, 2'd3, 32'h04030201, 5, "wrap");
        for (int i = 0; i < 4 && i < alog.size(); i++) begin
            checks++;
            if (alog[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, alog[i], ea[i]); end
        end
    endtask

    task automatic test_drop_before_grant;
        bit saw_busy;
        saw_busy = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        rdy_in = 1'b0;
        drive_req(1, 1'b1, 32'h600, 32'h55, 2'd0);
        repeat (2) @(posedge clk);
        #1 req_valid[1] = 1'b0;
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        checks++;
        if (saw_busy !== 1'b0 || done_cnt[1] != 0 || wlog_a.size() != 0) begin
            errors++; $display("FAIL drop_ignored: got busy=%b done=%0d writes=%0d expected 0/0/0", saw_busy, done_cnt[1], wlog_a.size());
        end
    endtask

    task automatic test_reset_mid_write;
        bit ok;
        bit hit;
        @(posedge clk); #1;
        clear_logs();
        drive_req(0, 1'b1, 32'h300, 32'h44332211, 2'd3);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (mem_a === 32'h301 && mem_wr === 1'b1) hit = 1'b1;
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rstw_reach_byte1: got %b expected 1", hit); end
        @(posedge clk); #1 rdy_in = 1'b0;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rstw_wr_gated: got %b expected 0", mem_wr); end
        @(posedge clk); #1;
        rdy_in = 1'b1; rst = 1'b1; req_valid = 2'b00;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b0 || busy !== 1'b0 || resp_done !== 2'b00 || mem_a !== 32'h0) begin
            errors++; $display("FAIL rstw_after: got wr=%b busy=%b done=%b a=%h expected 0/0/00/00000000", mem_wr, busy, resp_done, mem_a);
        end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt[0] != 0) begin errors++; $display("FAIL rstw_no_done: got %0d expected 0", done_cnt[0]); end
        @(posedge clk); #1;
        clear_logs();
        drive_req(0, 1'b1, 32'h310, 32'h0000BEEF, 2'd1);
        wait_done(0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstw_new_timeout: got %b expected 1", ok); end
        @(posedge clk); #1 req_valid[0] = 1'b0;
        checks++;
        if (wlog_a.size() != 2 || done_cnt[0] != 1) begin
            errors++; $display("FAIL rstw_new_count: got %0d writes %0d done expected 2/1", wlog_a.size(), done_cnt[0]);
        end else begin
            checks++;
            if (wlog_a[0] !== 32'h310 || wlog_d[0] !== 8'hEF || wlog_a[1] !== 32'h311 || wlog_d[1] !== 8'hBE) begin
                errors++; $display("FAIL rstw_new_data: got %h/%h %h/%h expected 00000310/ef 00000311/be", wlog_a[0], wlog_d[0], wlog_a[1], wlog_d[1]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_stall_read();
        test_wrap();
        test_drop_before_grant();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter NPORT, default 2, number of requester ports (1..4).
REQ-002 SHALL have parameter ADDR_W, default 32, address width of requests and mem_a.
REQ-003 SHALL have ports: clk  in  1  system clock, rising-edge; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port rdy_in  in  1  global ready; low freezes block.
REQ-005 SHALL have ports req_valid in NPORT, req_wr in NPORT (1=write), req_addr in NPORT*ADDR_W, req_wdata in NPORT*32, req_len in NPORT*2 (bytes-1), packed port0 in LSBs.
REQ-006 SHALL have ports resp_done out NPORT (one-cycle pulse per port), resp_rdata out 32, busy out 1.
REQ-007 SHALL have ports mem_din in 8, mem_dout out 8, mem_a out ADDR_W, mem_wr out 1 (1=write).

Function
REQ-008 SHALL implement FSM IDLE, READ, WRITE, DONE; advance only in cycles with rdy_in=1.
REQ-009 In IDLE with any req_valid, SHALL latch the winner's wr/addr/wdata/len and enter READ or WRITE next cycle; busy=1 from that cycle until the DONE cycle inclusive.
REQ-010 Requester SHALL hold req_valid and fields stable until its resp_done; block samples them only at grant.
REQ-011 Byte k (k=0..len) SHALL use address addr+k, modulo 2^ADDR_W; data little-endian (byte k = bits 8k+7:8k).
REQ-012 WRITE: one byte per cycle, mem_wr=1, mem_dout=byte k, mem_a=addr+k; len+1 cycles, then DONE.
REQ-013 READ: address k issued in cycle t, mem_din sampled in cycle t+1 as byte k; addresses pipelined; len+2 cycles, then DONE.
REQ-014 resp_rdata SHALL zero-extend unread upper bytes and remain stable until the next read completes.
REQ-015 DONE SHALL last one cycle, pulse resp_done for the granted port only, return to IDLE; new grant not earlier than the following cycle.
REQ-016 mem_wr SHALL be 0 in IDLE, READ, DONE, and in any cycle with rdy_in=0.
REQ-017 rdy_in low mid-transfer: hold state, mem_a and byte index; in-flight read byte discarded; on resume, current byte re-issued (write re-driven with mem_wr=1, read re-addressed, one extra latency cycle).
REQ-018 A req_valid deasserted before grant SHALL be ignored; no response issued.

Reset
REQ-019 rst=1 SHALL take precedence over rdy_in and abort any transfer without resp_done.
REQ-020 After reset: state IDLE, mem_a=0, mem_dout=0, mem_wr=0, resp_done=0, resp_rdata=0, busy=0, arbitration pointer=0.

Configuration
REQ-021 Macro MEM_ARB_RR_EN defined: round-robin grant, search starts at port after last-granted index, pointer updated on grant.
REQ-022 MEM_ARB_RR_EN undefined: fixed priority, lowest-index valid port wins; no pointer state.

Verification
REQ-023 Port0 write len=3 addr 0x100 data 0xDDCCBBAA -> mem_wr=1 four cycles, mem_a 0x100..0x103, mem_dout AA,BB,CC,DD; resp_done[0] once.
REQ-024 Port1 read len=1 addr 0x200, memory 0x34,0x12 -> resp_rdata=0x00001234 after 3 cycles in READ; resp_done[1] pulses.
REQ-025 Ports 0 and 1 request same cycle, repeatedly -> fixed: port0 always first; RR_EN: grants alternate 0,1,0,1.
REQ-026 rdy_in low 3 cycles during byte 2 of 4-byte read -> mem_wr=0, no state change; byte 2 re-fetched; final data correct.
REQ-027 Read len=3 at addr 0xFFFFFFFE (ADDR_W=32) -> mem_a 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
REQ-028 rst asserted mid-write -> next cycle mem_wr=0, busy=0, no resp_done, IDLE; new request then served normally.
